// File: rtl/instr_mem_pkg.sv
// Shared types and sizing helpers for the instruction memory controller.
// Prefetch support is enabled by defining INSTR_MEM_PREFETCH_EN.
package instr_mem_pkg;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {PF_IDLE, PF_BUSY} pf_state_t;

    // Bytes per instruction word.
    function automatic int calc_wb(input int instr_w);
        return instr_w / 8;
    endfunction

    // Number of byte-offset bits inside one word.
    function automatic int calc_off_w(input int instr_w);
        return $clog2(instr_w / 8);
    endfunction

    // Number of byte-address bits that select a location in the array.
    function automatic int calc_idx_w(input int depth_bytes);
        return $clog2(depth_bytes);
    endfunction

    // Wait counter width; at least one bit even for a single-cycle latency.
    function automatic int calc_cnt_w(input int read_latency);
        return (read_latency > 1) ? $clog2(read_latency) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Byte-wide program store: synchronous byte write, combinational
// big-endian read of WB consecutive bytes starting at an aligned address.
module instr_mem_array #(
    parameter int WB          = 4,
    parameter int DEPTH_BYTES = 1024,
    parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [7:0]        wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [8*WB-1:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // NOTE: the array has no reset; program contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Lowest address lands in the most significant byte.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < WB; i++) begin
            rdata[8*(WB-1-i) +: 8] = mem[raddr + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: multi-cycle reads with a BUSYWAIT stall,
// one-word hit buffer and byte loader. Optional INSTR_MEM_PREFETCH_EN.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int INSTR_W      = 32,
    parameter int DEPTH_BYTES  = 1024,
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic [ADDR_W-1:0]  ADDRESS,
    output logic [INSTR_W-1:0] READDATA,
    output logic               BUSYWAIT,
    input  logic               LOAD_EN,
    input  logic [ADDR_W-1:0]  LOAD_ADDR,
    input  logic [7:0]         LOAD_DATA,
    output logic               MISALIGN
);

    localparam int WB     = calc_wb(INSTR_W);
    localparam int OFF_W  = calc_off_w(INSTR_W);
    localparam int IDX_W  = calc_idx_w(DEPTH_BYTES);
    localparam int WIDX_W = IDX_W - OFF_W;
    localparam int CNT_W  = calc_cnt_w(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WIDX_W-1:0]   last_addr, last_addr_nxt;
    logic                last_valid;
    logic                accept, complete, pf_take;

    logic [WIDX_W-1:0]   req_word, load_word, rd_word;
    logic [INSTR_W-1:0]  rd_data;
    logic                misaligned, hit;
    logic                unused_addr_bits;

    assign req_word   = ADDRESS[IDX_W-1:OFF_W];
    assign load_word  = LOAD_ADDR[IDX_W-1:OFF_W];
    assign misaligned = |(ADDRESS & ADDR_W'(WB - 1));
    assign hit        = last_valid && (req_word == last_addr);
    assign BUSYWAIT   = (state == BUSY) || (state == IDLE && READ && !hit);
    assign unused_addr_bits = ^LOAD_ADDR[ADDR_W-1:IDX_W];

    // A single-cycle latency completes straight from IDLE, before last_addr updates.
    assign rd_word = (state == IDLE) ? req_word : last_addr;

    instr_mem_array #(.WB(WB), .DEPTH_BYTES(DEPTH_BYTES), .IDX_W(IDX_W)) u_array (
        .clk   (CLK),
        .we    (LOAD_EN),
        .waddr (LOAD_ADDR[IDX_W-1:0]),
        .wdata (LOAD_DATA),
        .raddr (IDX_W'(rd_word) << OFF_W),
        .rdata (rd_data)
    );

`ifdef INSTR_MEM_PREFETCH_EN
    pf_state_t           pf_state, pf_state_nxt;
    logic [CNT_W-1:0]    pf_cnt;
    logic [WIDX_W-1:0]   pf_addr;
    logic [INSTR_W-1:0]  pf_data, pf_rd_data;
    logic                pf_valid;

    instr_mem_array #(.WB(WB), .DEPTH_BYTES(DEPTH_BYTES), .IDX_W(IDX_W)) u_pf_array (
        .clk   (CLK),
        .we    (LOAD_EN),
        .waddr (LOAD_ADDR[IDX_W-1:0]),
        .wdata (LOAD_DATA),
        .raddr (IDX_W'(pf_addr) << OFF_W),
        .rdata (pf_rd_data)
    );
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        last_addr_nxt = last_addr;
        accept        = 1'b0;
        complete      = 1'b0;
        pf_take       = 1'b0;
`ifdef INSTR_MEM_PREFETCH_EN
        pf_state_nxt  = pf_state;
`endif
        case (state)
            IDLE: begin
                if (READ && !hit) begin
`ifdef INSTR_MEM_PREFETCH_EN
                    // Buffered word: one-cycle copy. In-flight word: stall until it lands.
                    if (pf_valid && req_word == pf_addr) begin
                        pf_take = 1'b1;
                    end else if (!(pf_state == PF_BUSY && req_word == pf_addr)) begin
                        accept = 1'b1;
                    end
`else
                    accept = 1'b1;
`endif
                end
            end
            BUSY: begin
                // cnt counts remaining edges including the current one.
                if (cnt == CNT_W'(1)) begin
                    complete = 1'b1;
                end
            end
            default: ;
        endcase

        if (accept) begin
            last_addr_nxt = req_word;
            if (READ_LATENCY == 1) begin
                complete = 1'b1;
            end else begin
                state_nxt = BUSY;
            end
        end
        if (complete) begin
            state_nxt = IDLE;
        end
`ifdef INSTR_MEM_PREFETCH_EN
        if (pf_take) begin
            last_addr_nxt = pf_addr;
        end
        if (complete || pf_take) begin
            pf_state_nxt = PF_BUSY;
        end else if (accept) begin
            pf_state_nxt = PF_IDLE;
        end else if (pf_state == PF_BUSY && pf_cnt == '0) begin
            pf_state_nxt = PF_IDLE;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; later assignments in this block take priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            last_addr  <= '0;
            last_valid <= 1'b0;
            READDATA   <= '0;
            MISALIGN   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_addr <= last_addr_nxt;
            if (state == IDLE && READ && misaligned) begin
                MISALIGN <= 1'b1;
            end
            if (accept) begin
                cnt        <= CNT_LOAD;
                last_valid <= 1'b0;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (complete) begin
                READDATA   <= rd_data;
                last_valid <= 1'b1;
            end
`ifdef INSTR_MEM_PREFETCH_EN
            if (pf_take) begin
                READDATA   <= pf_data;
                last_valid <= 1'b1;
            end
`endif
            // A load into the buffered word invalidates it, even on the completing edge.
            if (LOAD_EN && load_word == last_addr_nxt) begin
                last_valid <= 1'b0;
            end
        end
    end

`ifdef INSTR_MEM_PREFETCH_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pf_state <= PF_IDLE;
            pf_cnt   <= '0;
            pf_addr  <= '0;
            pf_data  <= '0;
            pf_valid <= 1'b0;
        end else begin
            pf_state <= pf_state_nxt;
            if (complete || pf_take) begin
                pf_addr  <= last_addr_nxt + WIDX_W'(1);
                pf_cnt   <= CNT_LOAD;
                pf_valid <= 1'b0;
            end else if (accept) begin
                pf_valid <= 1'b0;
            end else if (pf_state == PF_BUSY) begin
                if (pf_cnt == '0) begin
                    pf_data  <= pf_rd_data;
                    pf_valid <= 1'b1;
                end else begin
                    pf_cnt <= pf_cnt - CNT_W'(1);
                end
            end
            if (LOAD_EN && load_word == pf_addr) begin
                pf_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
